// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: x/y counters, pixel requests, frame/line strobes,
// and sync/DE/colour re-aligned to the pixel source read latency (PIPE clocks).
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit H_POL    = 1'b0,
   parameter bit V_POL    = 1'b0,
   parameter int CNT_W    = 10,
   parameter int COLOR_W  = 8,
   parameter int PIPE     = 2
) (
   input  logic               VGA_CLK_IN,
   input  logic               RST,
   input  logic               i_enable,
   input  logic [COLOR_W-1:0] i_red,
   input  logic [COLOR_W-1:0] i_green,
   input  logic [COLOR_W-1:0] i_blue,
   output logic [CNT_W-1:0]   o_x,
   output logic [CNT_W-1:0]   o_y,
   output logic               o_req,
   output logic               o_frame_start,
   output logic               o_line_start,
   output logic               o_hsync,
   output logic               o_vsync,
   output logic               o_de,
   output logic [COLOR_W-1:0] o_red,
   output logic [COLOR_W-1:0] o_green,
   output logic [COLOR_W-1:0] o_blue,
   output logic               VGA_CLK_OUT
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [31:0] H_ACT_W  = 32'(H_ACTIVE);
   localparam logic [31:0] V_ACT_W  = 32'(V_ACTIVE);
   localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
   localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
   localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   // cx/cy hold the position to be presented on the next enabled clock, so the
   // first enabled edge after reset or idle always presents (0,0).
   logic [CNT_W-1:0] cx;
   logic [CNT_W-1:0] cy;
   logic [31:0]      cx_w;
   logic [31:0]      cy_w;
   logic             raw_hs;
   logic             raw_vs;
   logic             raw_de;

   logic [PIPE:0]    hs_pipe;
   logic [PIPE:0]    vs_pipe;
   logic [PIPE:0]    de_pipe;

   assign VGA_CLK_OUT = VGA_CLK_IN;

   assign cx_w = 32'(cx);
   assign cy_w = 32'(cy);

   // vsync depends only on cy, which changes only when x wraps, so it moves at x=0.
   always_comb begin
      raw_hs = (cx_w >= HS_START) && (cx_w < HS_END);
      raw_vs = (cy_w >= VS_START) && (cy_w < VS_END);
      raw_de = (cx_w < H_ACT_W) && (cy_w < V_ACT_W);
   end

   // o_req is a pure request strobe: there is no ready, the source must answer
   // every request with colour exactly PIPE clocks later.
   always_ff @(posedge VGA_CLK_IN or posedge RST) begin
      if (RST) begin
         cx            <= '0;
         cy            <= '0;
         o_x           <= '0;
         o_y           <= '0;
         o_req         <= 1'b0;
         o_frame_start <= 1'b0;
         o_line_start  <= 1'b0;
         hs_pipe       <= '0;
         vs_pipe       <= '0;
         de_pipe       <= '0;
         o_hsync       <= ~H_POL;
         o_vsync       <= ~V_POL;
         o_de          <= 1'b0;
         o_red         <= '0;
         o_green       <= '0;
         o_blue        <= '0;
      end else begin
         if (i_enable) begin
            o_x           <= cx;
            o_y           <= cy;
            o_req         <= raw_de;
            o_frame_start <= (cx == '0) && (cy == '0);
            o_line_start  <= (cx == '0);
            hs_pipe[0]    <= raw_hs;
            vs_pipe[0]    <= raw_vs;
            de_pipe[0]    <= raw_de;
            if (cx == H_LAST) begin
               cx <= '0;
               cy <= (cy == V_LAST) ? '0 : cy + 1'b1;
            end else begin
               cx <= cx + 1'b1;
            end
         end else begin
            cx            <= '0;
            cy            <= '0;
            o_x           <= '0;
            o_y           <= '0;
            o_req         <= 1'b0;
            o_frame_start <= 1'b0;
            o_line_start  <= 1'b0;
            hs_pipe[0]    <= 1'b0;
            vs_pipe[0]    <= 1'b0;
            de_pipe[0]    <= 1'b0;
         end

         for (int k = 1; k <= PIPE; k++) begin
            hs_pipe[k] <= hs_pipe[k-1];
            vs_pipe[k] <= vs_pipe[k-1];
            de_pipe[k] <= de_pipe[k-1];
         end

         o_hsync <= hs_pipe[PIPE] ? H_POL : ~H_POL;
         o_vsync <= vs_pipe[PIPE] ? V_POL : ~V_POL;
         o_de    <= de_pipe[PIPE];
         o_red   <= de_pipe[PIPE] ? i_red   : '0;
         o_green <= de_pipe[PIPE] ? i_green : '0;
         o_blue  <= de_pipe[PIPE] ? i_blue  : '0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two configurations (small active-low PIPE=2 with a
// 2-clock ROM source, medium active-high PIPE=0 with a combinational source).
module tb_vga_timing_gen;

   localparam int W = 62;

   localparam int A_HA = 8,  A_HF = 1, A_HS = 2, A_HB = 1;
   localparam int A_VA = 4,  A_VF = 1, A_VS = 1, A_VB = 1;
   localparam int A_CW = 4,  A_PIPE = 2;
   localparam bit A_HP = 1'b0, A_VP = 1'b0;

   localparam int B_HA = 20, B_HF = 3, B_HS = 4, B_HB = 5;
   localparam int B_VA = 6,  B_VF = 2, B_VS = 2, B_VB = 3;
   localparam int B_CW = 6,  B_PIPE = 0;
   localparam bit B_HP = 1'b1, B_VP = 1'b1;

   logic clk;
   logic rst;
   logic en;
   logic [23:0] key;

   logic [7:0] i_red_a, i_green_a, i_blue_a, o_red_a, o_green_a, o_blue_a;
   logic [A_CW-1:0] o_x_a, o_y_a;
   logic o_req_a, o_fs_a, o_ls_a, o_hs_a, o_vs_a, o_de_a, clk_out_a;

   logic [7:0] i_red_b, i_green_b, i_blue_b, o_red_b, o_green_b, o_blue_b;
   logic [B_CW-1:0] o_x_b, o_y_b;
   logic o_req_b, o_fs_b, o_ls_b, o_hs_b, o_vs_b, o_de_b, clk_out_b;

   logic [W-1:0] exp_q_a[$];
   logic [W-1:0] exp_q_b[$];
   int hist_a[$];
   int hist_b[$];
   int next_a, next_b;
   int n_vec, n_err;

   logic [23:0] rom1_a, rom2_a;

   vga_timing_gen #(
      .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
      .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
      .H_POL(A_HP), .V_POL(A_VP), .CNT_W(A_CW), .COLOR_W(8), .PIPE(A_PIPE)
   ) dut_a (
      .VGA_CLK_IN(clk), .RST(rst), .i_enable(en),
      .i_red(i_red_a), .i_green(i_green_a), .i_blue(i_blue_a),
      .o_x(o_x_a), .o_y(o_y_a), .o_req(o_req_a),
      .o_frame_start(o_fs_a), .o_line_start(o_ls_a),
      .o_hsync(o_hs_a), .o_vsync(o_vs_a), .o_de(o_de_a),
      .o_red(o_red_a), .o_green(o_green_a), .o_blue(o_blue_a),
      .VGA_CLK_OUT(clk_out_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
      .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
      .H_POL(B_HP), .V_POL(B_VP), .CNT_W(B_CW), .COLOR_W(8), .PIPE(B_PIPE)
   ) dut_b (
      .VGA_CLK_IN(clk), .RST(rst), .i_enable(en),
      .i_red(i_red_b), .i_green(i_green_b), .i_blue(i_blue_b),
      .o_x(o_x_b), .o_y(o_y_b), .o_req(o_req_b),
      .o_frame_start(o_fs_b), .o_line_start(o_ls_b),
      .o_hsync(o_hs_b), .o_vsync(o_vs_b), .o_de(o_de_b),
      .o_red(o_red_b), .o_green(o_green_b), .o_blue(o_blue_b),
      .VGA_CLK_OUT(clk_out_b)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- pixel sources ----------------
   function automatic logic [23:0] color(input int x, input int y, input logic [23:0] k);
      logic [7:0] xb, yb;
      xb = x[7:0];
      yb = y[7:0];
      return {xb ^ k[23:16], yb ^ k[15:8], (xb ^ yb) ^ k[7:0]};
   endfunction

   always @(posedge clk) begin
      rom1_a <= color(int'(o_x_a), int'(o_y_a), key);
      rom2_a <= rom1_a;
   end
   assign {i_red_a, i_green_a, i_blue_a} = rom2_a;
   assign {i_red_b, i_green_b, i_blue_b} = color(int'(o_x_b), int'(o_y_b), key);

   // ---------------- reference model ----------------
   // p_now: frame-relative index of the position presented this clock (-1 = idle).
   // p_del: index presented PIPE+1 clocks ago, which drives sync/de/colour now.
   function automatic logic [W-1:0] model_out(
      input int ha, input int hf, input int hs, input int hb,
      input int va, input int vf, input int vs, input int vb,
      input bit hpol, input bit vpol, input int p_now, input int p_del);
      int ht, vt, x, y, dx, dy;
      logic req, fs, ls, hso, vso, de;
      logic [23:0] rgb;
      ht = ha + hf + hs + hb;
      vt = va + vf + vs + vb;
      x = 0; y = 0; req = 0; fs = 0; ls = 0;
      if (p_now >= 0) begin
         x   = p_now % ht;
         y   = (p_now / ht) % vt;
         req = (x < ha) && (y < va);
         fs  = (x == 0) && (y == 0);
         ls  = (x == 0);
      end
      hso = ~hpol; vso = ~vpol; de = 0; rgb = '0;
      if (p_del >= 0) begin
         dx = p_del % ht;
         dy = (p_del / ht) % vt;
         if (dx >= ha + hf && dx < ha + hf + hs) hso = hpol;
         if (dy >= va + vf && dy < va + vf + vs) vso = vpol;
         de = (dx < ha) && (dy < va);
         if (de) rgb = color(dx, dy, key);
      end
      return {16'(x), 16'(y), req, fs, ls, hso, vso, de, rgb};
   endfunction

   function automatic logic [W-1:0] exp_a(input int pn, input int pd);
      return model_out(A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, A_HP, A_VP, pn, pd);
   endfunction

   function automatic logic [W-1:0] exp_b(input int pn, input int pd);
      return model_out(B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, B_HP, B_VP, pn, pd);
   endfunction

   function automatic logic [W-1:0] got_a();
      return {16'(o_x_a), 16'(o_y_a), o_req_a, o_fs_a, o_ls_a, o_hs_a, o_vs_a, o_de_a,
              o_red_a, o_green_a, o_blue_a};
   endfunction

   function automatic logic [W-1:0] got_b();
      return {16'(o_x_b), 16'(o_y_b), o_req_b, o_fs_b, o_ls_b, o_hs_b, o_vs_b, o_de_b,
              o_red_b, o_green_b, o_blue_b};
   endfunction

   // Expected responses are pushed on every active edge.
   always @(posedge clk) begin
      int pn, pd;
      if (rst) begin
         hist_a.delete(); next_a = 0; pn = -1;
      end else if (!en) begin
         next_a = 0; pn = -1;
      end else begin
         pn = next_a; next_a++;
      end
      hist_a.push_front(pn);
      pd = (hist_a.size() > A_PIPE + 1) ? hist_a[A_PIPE + 1] : -1;
      exp_q_a.push_back(exp_a(pn, pd));
      if (hist_a.size() > 16) void'(hist_a.pop_back());

      if (rst) begin
         hist_b.delete(); next_b = 0; pn = -1;
      end else if (!en) begin
         next_b = 0; pn = -1;
      end else begin
         pn = next_b; next_b++;
      end
      hist_b.push_front(pn);
      pd = (hist_b.size() > B_PIPE + 1) ? hist_b[B_PIPE + 1] : -1;
      exp_q_b.push_back(exp_b(pn, pd));
      if (hist_b.size() > 16) void'(hist_b.pop_back());
   end

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      logic [W-1:0] e, g;
      if (exp_q_a.size() > 0) begin
         e = exp_q_a.pop_front();
         g = got_a();
         n_vec++;
         if (g !== e) begin
            n_err++;
            $display("FAIL dut_a t=%0t got=%h exp=%h", $time, g, e);
         end
      end
      if (exp_q_b.size() > 0) begin
         e = exp_q_b.pop_front();
         g = got_b();
         n_vec++;
         if (g !== e) begin
            n_err++;
            $display("FAIL dut_b t=%0t got=%h exp=%h", $time, g, e);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check_idle(input string tag);
      n_vec++;
      if (got_a() !== exp_a(-1, -1)) begin
         n_err++;
         $display("FAIL %s dut_a got=%h exp=%h", tag, got_a(), exp_a(-1, -1));
      end
      n_vec++;
      if (got_b() !== exp_b(-1, -1)) begin
         n_err++;
         $display("FAIL %s dut_b got=%h exp=%h", tag, got_b(), exp_b(-1, -1));
      end
      n_vec++;
      if (clk_out_a !== clk || clk_out_b !== clk) begin
         n_err++;
         $display("FAIL %s clk_out got=%b%b exp=%b", tag, clk_out_a, clk_out_b, clk);
      end
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rst_pulse(input int n);
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_idle("async_reset");
      repeat (n) @(negedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic drop_en(input int n);
      @(negedge clk);
      #2 en = 1'b0;
      repeat (n) @(negedge clk);
      #2 en = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_vec = 0;
      n_err = 0;
      next_a = 0;
      next_b = 0;
      en = 1'b0;
      rst = 1'b0;
      key = 24'($urandom);
      #1 rst = 1'b1;
      #1 check_idle("reset_state");

      @(negedge clk);
      #2 en = 1'b1;
      run(2);
      #2 rst = 1'b0;

      run(1300);            // > 3 frames of either configuration
      run($urandom_range(1, 200));
      rst_pulse(2);         // mid-frame reset with enable held high
      run(300);
      drop_en(50);          // idle gap in the middle of a line
      run(200);

      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 2))
            0:       run($urandom_range(1, 500));
            1:       drop_en($urandom_range(1, 60));
            default: rst_pulse($urandom_range(1, 3));
         endcase
      end
      run(100);
      run(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
